// File: rtl/pwm_pkg.sv
// Shared types and constants for the multi-channel PWM generator.
package pwm_pkg;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_e;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared period counter: edge/center counting, terminal detect and the
// registered period_end pulse.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int RESOLUTION = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [RESOLUTION-1:0] period_i,
    input  logic                  mode_i,
    output logic                  terminal_o,
    output logic                  period_end_o,
    output logic [RESOLUTION-1:0] counter_o,
    output dir_e                  dir_o
);

    localparam logic [RESOLUTION-1:0] ONE = RESOLUTION'(1);

    logic [RESOLUTION-1:0] cnt_q, cnt_d;
    dir_e                  dir_q, dir_d;
    logic                  period_end_q, period_end_d;
    logic                  terminal;

    // Center mode with P<=1 never enters DOWN, so it terminates at cnt==P.
    always_comb begin
        terminal = 1'b0;
        if (mode_i == MODE_EDGE) begin
            terminal = (cnt_q == period_i);
        end else begin
            terminal = ((dir_q == DOWN) && (cnt_q == ONE)) ||
                       ((period_i <= ONE) && (cnt_q == period_i));
        end
    end

    always_comb begin
        cnt_d        = cnt_q;
        dir_d        = dir_q;
        period_end_d = enable && terminal;
        if (!enable || terminal) begin
            cnt_d = '0;
            dir_d = UP;
        end else if (mode_i == MODE_EDGE) begin
            cnt_d = cnt_q + ONE;
        end else if (dir_q == UP) begin
            if (cnt_q == period_i) begin
                cnt_d = cnt_q - ONE;
                dir_d = DOWN;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end else begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            dir_q        <= UP;
            period_end_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            period_end_q <= period_end_d;
        end
    end

    assign terminal_o   = terminal;
    assign period_end_o = period_end_q;
    assign counter_o    = cnt_q;
    assign dir_o        = dir_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: double-buffered period/duty/mode registers feeding a
// shared timebase and one registered comparator per channel.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int RESOLUTION = 10,
    parameter int CHANNELS   = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic [RESOLUTION-1:0]           period_in,
    input  logic                            period_we,
    input  logic [RESOLUTION-1:0]           duty_in,
    input  logic [sel_width(CHANNELS)-1:0]  duty_sel,
    input  logic                            duty_we,
    input  logic                            mode_center,
    output logic [CHANNELS-1:0]             PWM_out,
    output logic                            period_end,
    output logic [RESOLUTION-1:0]           counter
);

    localparam int SEL_W = sel_width(CHANNELS);

    logic [RESOLUTION-1:0] period_sh_q, period_sh_d;
    logic [RESOLUTION-1:0] period_act_q, period_act_d;
    logic                  mode_sh_q, mode_sh_d;
    logic                  mode_act_q, mode_act_d;
    logic [CHANNELS-1:0]   pwm_q, pwm_d;
    logic                  terminal;
    logic                  load_act;
    logic [RESOLUTION-1:0] cnt;
    dir_e                  dir;

    pwm_timebase #(
        .RESOLUTION (RESOLUTION)
    ) u_timebase (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .period_i     (period_act_q),
        .mode_i       (mode_act_q),
        .terminal_o   (terminal),
        .period_end_o (period_end),
        .counter_o    (cnt),
        .dir_o        (dir)
    );

    // Actives follow shadows at a boundary or continuously while disabled;
    // a write landing on the terminal cycle is picked up one period later.
    assign load_act = !enable || terminal;

    always_comb begin
        period_sh_d  = period_we ? period_in : period_sh_q;
        mode_sh_d    = mode_center;
        period_act_d = load_act ? period_sh_q : period_act_q;
        mode_act_d   = load_act ? mode_sh_q : mode_act_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            period_sh_q  <= '1;
            period_act_q <= '1;
            mode_sh_q    <= MODE_EDGE;
            mode_act_q   <= MODE_EDGE;
            pwm_q        <= '0;
        end else begin
            period_sh_q  <= period_sh_d;
            period_act_q <= period_act_d;
            mode_sh_q    <= mode_sh_d;
            mode_act_q   <= mode_act_d;
            pwm_q        <= pwm_d;
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : ch_g
        logic [RESOLUTION-1:0] duty_sh_q, duty_sh_d;
        logic [RESOLUTION-1:0] duty_act_q, duty_act_d;
        logic                  hit;
        logic                  high;

        // Out-of-range selects match no channel and are dropped.
        assign hit = duty_we && (duty_sel == SEL_W'(gi));

        always_comb begin
            duty_sh_d  = hit ? duty_in : duty_sh_q;
            duty_act_d = load_act ? duty_sh_q : duty_act_q;
        end

        // On the way down the compare includes cnt==duty so the pulse is
        // 2*duty wide and symmetric about cnt=0; duty>=P saturates to 100%.
        always_comb begin
            high = 1'b0;
            if (mode_act_q == MODE_EDGE) begin
                high = (cnt < duty_act_q);
            end else begin
                high = (duty_act_q != '0) &&
                       ((duty_act_q >= period_act_q) ||
                        ((dir == DOWN) ? (cnt <= duty_act_q) : (cnt < duty_act_q)));
            end
        end

        assign pwm_d[gi] = enable && high;

        always_ff @(posedge clk) begin
            if (rst) begin
                duty_sh_q  <= '0;
                duty_act_q <= '0;
            end else begin
                duty_sh_q  <= duty_sh_d;
                duty_act_q <= duty_act_d;
            end
        end
    end

    assign PWM_out = pwm_q;
    assign counter = cnt;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: reset, edge/center timing, double buffering,
// edge cases, disable and mid-period reset.
module tb_pwm_multi;

    localparam int RES = 10;
    localparam int CH  = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic [RES-1:0]  period_in;
    logic            period_we;
    logic [RES-1:0]  duty_in;
    logic [1:0]      duty_sel;
    logic            duty_we;
    logic            mode_center;
    logic [CH-1:0]   PWM_out;
    logic            period_end;
    logic [RES-1:0]  counter;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm_multi #(
        .RESOLUTION (RES),
        .CHANNELS   (CH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .period_in   (period_in),
        .period_we   (period_we),
        .duty_in     (duty_in),
        .duty_sel    (duty_sel),
        .duty_we     (duty_we),
        .mode_center (mode_center),
        .PWM_out     (PWM_out),
        .period_end  (period_end),
        .counter     (counter)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_period(input int p);
        period_in = RES'(p);
        period_we = 1'b1;
        tick();
        period_we = 1'b0;
        $display("write period=%0d", p);
    endtask

    task automatic write_duty(input int sel, input int d);
        duty_sel = 2'(sel);
        duty_in  = RES'(d);
        duty_we  = 1'b1;
        tick();
        duty_we  = 1'b0;
        $display("write duty sel=%0d val=%0d", sel, d);
    endtask

    task automatic configure(input logic m, input int p, input int d0, input int d1, input int d2);
        enable      = 1'b0;
        mode_center = m;
        write_period(p);
        write_duty(0, d0);
        write_duty(1, d1);
        write_duty(2, d2);
        tick();
        enable = 1'b1;
        $display("configure mode=%0d P=%0d duty=%0d/%0d/%0d", m, p, d0, d1, d2);
    endtask

    initial begin
        int first_pe;
        int any_high;
        int idx;
        int j;
        int dexp;
        int cseq[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 7, 6, 5, 4, 3, 2, 1};

        rst = 1'b1; enable = 1'b0; period_in = '0; period_we = 1'b0;
        duty_in = '0; duty_sel = '0; duty_we = 1'b0; mode_center = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_pwm", PWM_out, 0);
        check("rst_pe", period_end, 0);
        check("rst_cnt", counter, 0);

        // Reset defaults: P=1023, all duties 0.
        enable   = 1'b1;
        first_pe = 0;
        any_high = 0;
        for (int k = 1; k <= 1025; k++) begin
            tick();
            if (period_end && first_pe == 0) first_pe = k;
            if (PWM_out != '0) any_high = 1;
            if (k == 1023) check("t1_cnt_top", counter, 1023);
            if (k == 1025) check("t1_pe_off", period_end, 0);
        end
        check("t1_first_pe", first_pe, 1024);
        check("t1_pwm_low", any_high, 0);
        $display("t1 reset defaults first_pe=%0d", first_pe);

        // Edge mode, P=9.
        configure(1'b0, 9, 3, 10, 0);
        for (int k = 1; k <= 30; k++) begin
            tick();
            check("t2_pwm", PWM_out, ((((k - 1) % 10) < 3) ? 1 : 0) + 2);
            check("t2_pe", period_end, (k % 10 == 0) ? 1 : 0);
            check("t2_cnt", counter, k % 10);
        end
        $display("t2 edge mode done");

        // Center mode, P=8, ch2 duty 2.
        configure(1'b1, 8, 0, 0, 2);
        for (int k = 1; k <= 32; k++) begin
            tick();
            idx = (k - 1) % 16;
            check("t3_cnt", counter, cseq[k % 16]);
            check("t3_pwm", PWM_out, (idx == 14 || idx == 15 || idx == 0 || idx == 1) ? 4 : 0);
            check("t3_pe", period_end, (k % 16 == 0) ? 1 : 0);
        end
        $display("t3 center mode done");

        // Double buffering: write at cnt=4, then on the terminal cycle.
        configure(1'b0, 9, 3, 0, 0);
        for (int k = 1; k <= 40; k++) begin
            if (k == 5) begin duty_sel = 2'd0; duty_in = RES'(7); duty_we = 1'b1; end
            if (k == 20) begin duty_sel = 2'd0; duty_in = RES'(1); duty_we = 1'b1; end
            tick();
            duty_we = 1'b0;
            dexp = (k <= 10) ? 3 : ((k <= 30) ? 7 : 1);
            check("t4_pwm", PWM_out, (((k - 1) % 10) < dexp) ? 1 : 0);
            check("t4_pe", period_end, (k % 10 == 0) ? 1 : 0);
        end
        $display("t4 double buffering done");

        // P=0: terminal every cycle.
        configure(1'b0, 0, 1, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("t5_p0_cnt", counter, 0);
            check("t5_p0_pe", period_end, 1);
            check("t5_p0_pwm", PWM_out, 1);
        end
        write_duty(3, 5);
        tick();
        tick();
        check("t5_badsel", PWM_out, 1);
        write_duty(1, 2);
        tick();
        check("t5_sel1_old", PWM_out, 1);
        tick();
        check("t5_sel1_new", PWM_out, 3);
        $display("t5 P=0 and select range done");

        // Mode switch mid-period applies at the boundary.
        configure(1'b0, 9, 3, 0, 0);
        for (int k = 1; k <= 30; k++) begin
            if (k == 5) mode_center = 1'b1;
            tick();
            if (k <= 10) begin
                check("t5_ms_cnt", counter, k % 10);
            end else begin
                j = (k - 10) % 18;
                check("t5_ms_cnt", counter, (j <= 9) ? j : 18 - j);
            end
            check("t5_ms_pe", period_end, (k == 10 || k == 28) ? 1 : 0);
        end
        $display("t5 mode switch done");

        // Disable mid-period.
        configure(1'b0, 9, 3, 0, 0);
        tick();
        tick();
        check("t6_pwm_run", PWM_out, 1);
        enable = 1'b0;
        tick();
        check("t6_dis_cnt", counter, 0);
        tick();
        check("t6_dis_pwm", PWM_out, 0);
        check("t6_dis_pe", period_end, 0);
        enable = 1'b1;
        tick();
        check("t6_re_cnt", counter, 1);
        check("t6_re_pwm", PWM_out, 1);

        // Reset mid-period discards the pending period write.
        write_period(5);
        tick();
        rst = 1'b1;
        tick();
        check("t6_rst_cnt", counter, 0);
        check("t6_rst_pwm", PWM_out, 0);
        check("t6_rst_pe", period_end, 0);
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("t6_post_cnt", counter, k);
            check("t6_post_pwm", PWM_out, 0);
        end
        $display("t6 disable and reset done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
